// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// Double-buffered digit data, blanking gap per slot, registered active-low anodes.
module seg_scan_ctrl #(
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_mask,
   input  logic                  load,
   output logic                  pending,
   output logic [3:0]            hex_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   function automatic logic [3:0] sel_nibble(input logic [4*DIGITS-1:0] data,
                                             input logic [IDX_W-1:0]    idx);
      logic [3:0] res;
      res = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            res = data[4*i +: 4];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic sel_bit(input logic [DIGITS-1:0] vec,
                                    input logic [IDX_W-1:0]  idx);
      logic res;
      res = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            res = vec[i];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Only the selected digit may drop its anode, and only while showing.
   function automatic logic [DIGITS-1:0] anode_vec(input logic              show,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic [DIGITS-1:0] en);
      logic [DIGITS-1:0] res;
      res = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (show && (idx == IDX_W'(i))) begin
            res[i] = ~en[i];
         end else begin
            res[i] = 1'b1;
         end
      end
      return res;
   endfunction

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0]  shadow_data_q, shadow_data_d;
   logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
   logic [4*DIGITS-1:0]  active_data_q, active_data_d;
   logic [DIGITS-1:0]    active_dp_q, active_dp_d;
   logic                 pending_q, pending_d;
   logic [3:0]           hex_q;
   logic                 dp_q;
   logic [DIGITS-1:0]    an_q;
   logic                 frame_done_q;
   logic                 boundary_s;

   assign boundary_s = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

   // Slot counter, digit index and BLANK/SHOW next-state decision.
   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      state_d = state_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_BLANK_LAST) begin
               state_d = ST_SHOW;
            end else begin
               state_d = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_BLANK;
            end else begin
               state_d = ST_SHOW;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Shadow capture on load; shadow-to-active transfer only at the frame boundary.
   always_comb begin
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      active_data_d = active_data_q;
      active_dp_d   = active_dp_q;
      pending_d     = pending_q;
      if (load) begin
         shadow_data_d = data_in;
         shadow_dp_d   = dp_in;
         pending_d     = 1'b1;
      end else begin
         pending_d = pending_q;
      end
      if (boundary_s) begin
         if (load) begin
            active_data_d = data_in;
            active_dp_d   = dp_in;
            pending_d     = 1'b0;
         end else if (pending_q) begin
            active_data_d = shadow_data_q;
            active_dp_d   = shadow_dp_q;
            pending_d     = 1'b0;
         end else begin
            pending_d = pending_q;
         end
      end else begin
         active_data_d = active_data_q;
      end
   end

   // State and output registers; outputs are derived from next-state so they line up with cnt_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_BLANK;
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         active_data_q <= '0;
         active_dp_q   <= '0;
         pending_q     <= 1'b0;
         hex_q         <= 4'h0;
         dp_q          <= 1'b1;
         an_q          <= '1;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         active_data_q <= active_data_d;
         active_dp_q   <= active_dp_d;
         pending_q     <= pending_d;
         hex_q         <= sel_nibble(active_data_d, idx_d);
         dp_q          <= ~sel_bit(active_dp_d, idx_d);
         an_q          <= anode_vec(state_d == ST_SHOW, idx_d, en_mask);
         frame_done_q  <= (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
      end
   end

   assign pending    = pending_q;
   assign hex_out    = hex_q;
   assign dp_out     = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expectations are queued per cycle, a monitor pops and compares.
module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  en_mask;
   logic        load;
   logic        pending;
   logic [3:0]  hex_out;
   logic        dp_out;
   logic [3:0]  an;
   logic        frame_done;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      string      name;
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       pend;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .en_mask    (en_mask),
      .load       (load),
      .pending    (pending),
      .hex_out    (hex_out),
      .dp_out     (dp_out),
      .an         (an),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int c, input string nm, input logic [3:0] a,
                            input logic [3:0] h, input logic d, input logic p, input logic f);
      exp_t e;
      e.cyc = c; e.name = nm; e.an = a; e.hex = h; e.dp = d; e.pend = p; e.fd = f;
      exp_q.push_back(e);
   endtask

   task automatic at_cyc(input int n);
      while (cyc != n) @(negedge clk);
   endtask

   // Monitor: compare every queued expectation due at this cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         cur = exp_q.pop_front();
         checks++;
         if (cur.cyc != cyc ||
             {an, hex_out, dp_out, pending, frame_done} !==
             {cur.an, cur.hex, cur.dp, cur.pend, cur.fd}) begin
            errors++;
            $display("FAIL %s @cyc%0d: got an=%b hex=%h dp=%b pend=%b fd=%b, want an=%b hex=%h dp=%b pend=%b fd=%b",
                     cur.name, cyc, an, hex_out, dp_out, pending, frame_done,
                     cur.an, cur.hex, cur.dp, cur.pend, cur.fd);
         end
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; data_in = 16'h0000; dp_in = 4'b0000; en_mask = 4'hF;

      // reset and first frame after release (release after edge 3)
      expect_at(1,  "rst1",        4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(3,  "rst3",        4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(4,  "blank0",      4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(5,  "show0_first", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(10, "show0_last",  4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(11, "blank1",      4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      // load 4321 mid-frame
      expect_at(12, "pre_load",    4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(13, "pending_set", 4'hD, 4'h0, 1'b1, 1'b1, 1'b0);
      expect_at(33, "pre_bound",   4'h7, 4'h0, 1'b1, 1'b1, 1'b0);
      expect_at(34, "bound1",      4'h7, 4'h0, 1'b1, 1'b1, 1'b1);
      expect_at(35, "f2_d0_blank", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
      expect_at(37, "f2_d0",       4'hE, 4'h1, 1'b1, 1'b0, 1'b0);
      expect_at(45, "f2_d1",       4'hD, 4'h2, 1'b1, 1'b0, 1'b0);
      expect_at(51, "f2_d2_blank", 4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_at(53, "f2_d2",       4'hB, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_at(61, "f2_d3",       4'h7, 4'h4, 1'b1, 1'b0, 1'b0);
      expect_at(65, "f2_prebound", 4'h7, 4'h4, 1'b1, 1'b0, 1'b0);
      expect_at(66, "bound2",      4'h7, 4'h4, 1'b1, 1'b0, 1'b1);
      // en_mask 1010
      expect_at(69, "mask_d0",     4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
      expect_at(74, "mask_d0_end", 4'hF, 4'h1, 1'b1, 1'b0, 1'b0);
      expect_at(77, "mask_d1",     4'hD, 4'h2, 1'b1, 1'b0, 1'b0);
      expect_at(85, "mask_d2",     4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_at(90, "mask_d2_end", 4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_at(93, "mask_d3",     4'h7, 4'h4, 1'b1, 1'b0, 1'b0);
      expect_at(97, "mask_prebnd", 4'h7, 4'h4, 1'b1, 1'b0, 1'b0);
      expect_at(98, "bound3",      4'h7, 4'h4, 1'b1, 1'b0, 1'b1);
      // two loads AAAA then BBBB
      expect_at(101, "loadA_pend", 4'hE, 4'h1, 1'b1, 1'b1, 1'b0);
      expect_at(120, "loadB_pend", 4'hB, 4'h3, 1'b0, 1'b1, 1'b0);
      expect_at(130, "bound4",     4'h7, 4'h4, 1'b1, 1'b1, 1'b1);
      expect_at(133, "f5_d0",      4'hE, 4'hB, 1'b1, 1'b0, 1'b0);
      expect_at(141, "f5_d1",      4'hD, 4'hB, 1'b1, 1'b0, 1'b0);
      expect_at(149, "f5_d2",      4'hB, 4'hB, 1'b1, 1'b0, 1'b0);
      expect_at(157, "f5_d3",      4'h7, 4'hB, 1'b1, 1'b0, 1'b0);
      // load exactly on boundary
      expect_at(162, "bound5_load", 4'h7, 4'hB, 1'b1, 1'b0, 1'b1);
      expect_at(163, "f6_d0_blank", 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
      expect_at(165, "f6_d0",       4'hE, 4'hF, 1'b0, 1'b0, 1'b0);
      // pending load, then reset while on digit 2
      expect_at(166, "f6_pend",     4'hE, 4'hF, 1'b0, 1'b1, 1'b0);
      expect_at(173, "f6_d1",       4'hD, 4'hE, 1'b1, 1'b1, 1'b0);
      expect_at(181, "f6_d2",       4'hB, 4'hD, 1'b1, 1'b1, 1'b0);
      expect_at(182, "mid_rst",     4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(184, "post_rst_d0", 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(189, "post_rst_end",4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(190, "post_rst_d1", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      expect_at(213, "post_rst_bnd",4'h7, 4'h0, 1'b1, 1'b0, 1'b1);
      expect_at(214, "post_rst_f2", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);

      at_cyc(3);   rst = 1'b0;
      at_cyc(12);  load = 1'b1; data_in = 16'h4321; dp_in = 4'b0100;
      at_cyc(13);  load = 1'b0;
      at_cyc(66);  en_mask = 4'b1010;
      at_cyc(98);  en_mask = 4'hF;
      at_cyc(100); load = 1'b1; data_in = 16'hAAAA; dp_in = 4'b0000;
      at_cyc(101); load = 1'b0;
      at_cyc(110); load = 1'b1; data_in = 16'hBBBB; dp_in = 4'b0000;
      at_cyc(111); load = 1'b0;
      at_cyc(162); load = 1'b1; data_in = 16'hCDEF; dp_in = 4'b0001;
      at_cyc(163); load = 1'b0;
      at_cyc(165); load = 1'b1; data_in = 16'h1234; dp_in = 4'b0000;
      at_cyc(166); load = 1'b0;
      at_cyc(181); rst = 1'b1;
      at_cyc(182); rst = 1'b0;
      at_cyc(220);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It sequences one shared hex-to-segment decoder (4-bit nibble in, 8-bit active-low a..g,dp out) across DIGITS digits. For each digit it selects the nibble, the decimal-point request and the active-low anode, and inserts a blanking gap between digits to suppress ghosting. Display data is double-buffered, so a host write never tears a frame. The block sits between the register/host logic and the decoder plus anode pins.

Parameters:
DIGITS, 8, number of digits scanned (legal 1..8)
SCAN_DIV, 50000, clock cycles per digit slot (legal > BLANK_CYC)
BLANK_CYC, 500, cycles at the start of each slot with all anodes off (legal >= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
data_in  input  4*DIGITS  nibble per digit; digit i = data_in[4i+3:4i]
dp_in  input  DIGITS  decimal-point request per digit, 1 = lit
en_mask  input  DIGITS  digit enable, 1 = digit may light; sampled live, not buffered
load  input  1  one-cycle strobe; captures data_in/dp_in into the shadow buffer
pending  output  1  shadow buffer holds data not yet shown
hex_out  output  4  nibble to the decoder for the current digit
dp_out  output  1  active-low dp to the pin (0 = lit)
an  output  DIGITS  active-low anode selects
frame_done  output  1  one-cycle pulse at the end of each full frame

Behaviour:
- Single clock. Reset is synchronous and active-high, named rst; the clock is named clk. All outputs are registered.
- Reset values:
  - an = all 1s; hex_out = 0; dp_out = 1; pending = 0; frame_done = 0.
  - Shadow and active buffers = 0.
  - State = BLANK, digit index = 0, slot counter = 0.
- Slot counter counts 0..SCAN_DIV-1, then wraps to 0.
- States:
  - BLANK while cnt < BLANK_CYC.
  - SHOW for cnt in BLANK_CYC..SCAN_DIV-1.
  - BLANK->SHOW occurs when cnt reaches BLANK_CYC. SHOW->BLANK occurs at wrap, and the digit index advances at the same time.
- Digit index:
  - Wraps DIGITS-1 -> 0.
  - Disabled digits are not skipped: their slot still elapses with an all 1s, which keeps duty cycle and brightness constant.
- In BLANK: an = all 1s.
- In SHOW: an[idx] = ~en_mask[idx]; all other bits = 1.
- hex_out and dp_out track the active buffer for the current idx through the whole slot, including BLANK, so the decoder output settles before the anode turns on.
- Anode timing: the first SHOW cycle of a slot has an[idx] = 0, registered at cnt = BLANK_CYC. One-cycle output latency from the state decision is permitted, provided it applies uniformly to an, hex_out and dp_out.
- Buffer update on load: shadow <= {data_in, dp_in}; pending <= 1.
- Frame boundary is the last cycle of the last digit's SHOW (idx = DIGITS-1, cnt = SCAN_DIV-1). At that cycle:
  - frame_done = 1 for that one cycle.
  - If pending: active <= shadow and pending <= 0. New data is visible from digit 0 of the next frame.
- Load on the boundary cycle: active <= data_in/dp_in directly, shadow is updated too, pending = 0.
- A second load before the boundary overwrites the shadow; the last write wins.
- DIGITS = 1: the frame is a single slot, and frame_done pulses every SCAN_DIV cycles.
- rst asserted mid-frame: all state returns to reset values on the next edge, and any pending data is discarded.
- Counter widths use clog2 of SCAN_DIV and DIGITS. No overflow is possible.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
1. Hold rst 3 cycles -> an=4'b1111, hex_out=0, dp_out=1, pending=0, frame_done=0. First an[0]=0 appears 2 cycles after rst release and lasts 6 cycles.
2. Load data_in=16'h4321, dp_in=4'b0100, en_mask=4'hF mid-frame -> pending=1 until the boundary.
   - frame_done pulses every 32 cycles.
   - Next frame: hex_out = 1,2,3,4 on digits 0..3, with dp_out=0 only on digit 2.
   - an pattern per slot: 2 cycles 1111, then 6 cycles 1110, 1101, 1011, 0111.
3. en_mask=4'b1010 -> digits 0 and 2 keep an=1111 for their whole slot. Frame period stays 32 cycles.
4. Two loads, 16'hAAAA then 16'hBBBB, in the same frame -> next frame shows B on all digits; A is never displayed.
5. load exactly on the boundary cycle with 16'hCDEF -> frame_done=1 and pending=0 that cycle; digit 0 of the next frame shows F.
6. rst pulse while idx=2 with pending=1 -> outputs return to reset values; after release, digit 0 shows 0 (active buffer cleared) and pending=0.
